mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 2, number of requesters (2..4).
REQ-002 Parameter: ADDR_W, default 5, memory address width.
REQ-003 Parameter: DATA_W, default 8, memory data width.
REQ-004 Port: clk  input  1  single clock; all state changes on posedge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: req  input  NUM_REQ  per-requester access request.
REQ-007 Port: req_we  input  NUM_REQ  per-requester command: 1 write, 0 read.
REQ-008 Port: req_addr  input  NUM_REQ*ADDR_W  per-requester address, packed, requester 0 in LSBs.
REQ-009 Port: req_wdata  input  NUM_REQ*DATA_W  per-requester write data, packed.
REQ-010 Port: gnt  output  NUM_REQ  one-hot one-cycle acceptance pulse.
REQ-011 Port: rvalid  output  NUM_REQ  one-hot one-cycle read-data-valid pulse.
REQ-012 Port: rdata  output  DATA_W  read data, shared; meaningful only while rvalid is set.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.
REQ-014 Port: mem_read  output  1  memory read strobe.
REQ-015 Port: mem_write  output  1  memory write strobe.
REQ-016 Port: mem_addr  output  ADDR_W  memory address.
REQ-017 Port: mem_data_in  output  DATA_W  data to memory.
REQ-018 Port: mem_data_out  input  DATA_W  data from memory; valid in the cycle after the mem_read cycle.

Function
REQ-019 FSM states: IDLE, ACCESS, CAPTURE.
REQ-020 IDLE with no req: remain IDLE; all strobes and pulses low.
REQ-021 IDLE with any req: at the clock edge, select a winner, latch its we/addr/wdata, set gnt[winner] for one cycle, set mem_write = we or mem_read = !we, and go to ACCESS.
REQ-022 ACCESS lasts exactly one cycle. Write: go to IDLE. Read: go to CAPTURE. Both strobes drop at the exit edge.
REQ-023 CAPTURE lasts one cycle; at its exit edge: rdata <= mem_data_out, rvalid[winner] <= 1 for one cycle, state <= IDLE.
REQ-024 Latency: gnt appears 1 cycle after req is sampled in IDLE; rvalid appears 3 cycles after that sampling.
REQ-025 Throughput: back-to-back writes, one per 2 cycles; back-to-back reads, one per 3 cycles.
REQ-026 Handshake: a requester holds req/we/addr/wdata stable until gnt; it deasserts req in the cycle after gnt, unless it is issuing a new request.
REQ-027 req seen in ACCESS or CAPTURE is ignored; it is sampled only in IDLE.
REQ-028 Arbitration is round-robin: the search starts at (last_winner+1) mod NUM_REQ; last_winner resets to NUM_REQ-1, so requester 0 wins first.
REQ-029 Simultaneous requests: exactly one gnt bit set; losers keep req and win in a later IDLE cycle. No requester waits more than NUM_REQ grants.
REQ-030 mem_addr and mem_data_in hold latched values from grant until the next grant; they are 0 after reset.
REQ-031 mem_read and mem_write are never high together.
REQ-032 gnt, rvalid, mem_read and mem_write are registered outputs; there is no combinational path from req to any output.

Reset
REQ-033 rst_n low forces, asynchronously: state IDLE, gnt = 0, rvalid = 0, rdata = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_data_in = 0, busy = 0, last_winner = NUM_REQ-1.
REQ-034 Reset asserted mid-ACCESS or mid-CAPTURE aborts the transaction; no rvalid is produced for it afterwards.
REQ-035 The first grant may occur at the first posedge after rst_n deasserts.

Structure
REQ-036 Package mem_arb_pkg holds ADDR_W/DATA_W defaults and the state enum typedef (IDLE, ACCESS, CAPTURE).
REQ-037 Sub-module rr_pick (combinational round-robin select: req vector + last_winner -> one-hot winner + index) is instantiated once.

Verification
REQ-038 Single write: req[0]=1, we=1, addr=5'h03, wdata=8'hA5 -> gnt[0] next cycle with mem_write=1, mem_addr=03, mem_data_in=A5 in that cycle; busy=1 for 1 cycle.
REQ-039 Single read: req[1]=1, we=0, addr=5'h03 -> mem_read pulse, then rvalid[1] 3 cycles after the request is sampled, with rdata=8'hA5.
REQ-040 Contention: req=2'b11 held after reset -> grant order 0,1,0,1; each gnt one-hot; no mem_read/mem_write overlap.
REQ-041 Reset mid-read: drop rst_n during CAPTURE -> all outputs 0 immediately; no rvalid after release.
REQ-042 Back-to-back: 4 writes on requester 0 to addrs 00..03 -> gnt every 2 cycles; readback of each address returns its written data.
REQ-043 Late req: requester 1 raises req during ACCESS -> no gnt until the next IDLE cycle; no request is lost.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: default widths, FSM state type
// and a helper for sizing requester index fields.
package mem_arb_pkg;

    localparam int NUM_REQ_DEFAULT = 2;
    localparam int ADDR_W_DEFAULT  = 5;
    localparam int DATA_W_DEFAULT  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    // A single requester still needs a one-bit index field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: scans requesters starting just after
// the previous winner and returns the first active one as one-hot and index.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] winner_onehot,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    int         cand;
    logic [IDX_W-1:0] cand_idx;
    logic       found;

    // The previous winner is visited last, so it only wins again when alone.
    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        any_req       = |req;
        found         = 1'b0;
        cand          = 0;
        cand_idx      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(last_winner) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found                   = 1'b1;
                winner_idx              = cand_idx;
                winner_onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters single-access turns on one
// synchronous memory port; reads return data two cycles after the grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       busy,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data_in,
    input  logic [DATA_W-1:0]          mem_data_out
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [IDX_W-1:0]   last_winner_q;
    logic               we_q;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_req;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    logic               grant_en;
    logic [NUM_REQ-1:0] gnt_d;
    logic [NUM_REQ-1:0] rvalid_d;
    logic               mem_read_d;
    logic               mem_write_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req           (req),
        .last_winner   (last_winner_q),
        .winner_onehot (pick_onehot),
        .winner_idx    (pick_idx),
        .any_req       (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = we_q ? IDLE : CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Requests are only looked at in IDLE; the in-flight winner is last_winner_q.
    always_comb begin
        grant_en    = (state_q == IDLE) && any_req;
        gnt_d       = grant_en ? pick_onehot : '0;
        mem_write_d = grant_en && req_we[pick_idx];
        mem_read_d  = grant_en && !req_we[pick_idx];
        rvalid_d    = (state_q == CAPTURE) ? (NUM_REQ'(1) << last_winner_q) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt           <= '0;
            rvalid        <= '0;
            rdata         <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_addr      <= '0;
            mem_data_in   <= '0;
            we_q          <= 1'b0;
            last_winner_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            gnt       <= gnt_d;
            rvalid    <= rvalid_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            if (grant_en) begin
                last_winner_q <= pick_idx;
                we_q          <= req_we[pick_idx];
                mem_addr      <= addr_arr[pick_idx];
                mem_data_in   <= wdata_arr[pick_idx];
            end
            if (state_q == CAPTURE) begin
                rdata <= mem_data_out;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus queues expected grants
// and read returns; a monitor matches them against DUT pulses.
module tb_mem_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [ADDR_W-1:0]         addr_a  [NUM_REQ];
    logic [DATA_W-1:0]         wdata_a [NUM_REQ];
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      mem_read;
    logic                      mem_write;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data_in;
    logic [DATA_W-1:0]         mem_data_out;

    logic [DATA_W-1:0]         mem [32];

    typedef struct {
        logic [NUM_REQ-1:0] gnt;
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
        int                 cyc;
    } gnt_exp_t;

    typedef struct {
        logic [NUM_REQ-1:0] rv;
        logic [DATA_W-1:0]  data;
        int                 cyc;
    } rv_exp_t;

    gnt_exp_t gnt_q [$];
    rv_exp_t  rv_q  [$];
    gnt_exp_t g;
    rv_exp_t  r;

    int cyc          = 0;
    int rv_seen      = 0;
    int n_compared   = 0;
    int n_mismatched = 0;

    assign req_addr  = {addr_a[1], addr_a[0]};
    assign req_wdata = {wdata_a[1], wdata_a[0]};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: read data shows up the cycle after mem_read.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        if (mem_read)  mem_data_out  <= mem[mem_addr];
    end

    mem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .busy         (busy),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void expectGnt(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                                      input logic [DATA_W-1:0] data, input int c);
        gnt_exp_t e;
        e.gnt  = NUM_REQ'(1) << idx;
        e.we   = we;
        e.addr = addr;
        e.data = data;
        e.cyc  = c;
        gnt_q.push_back(e);
    endfunction

    function automatic void expectRead(input int idx, input logic [DATA_W-1:0] data, input int c);
        rv_exp_t e;
        e.rv   = NUM_REQ'(1) << idx;
        e.data = data;
        e.cyc  = c;
        rv_q.push_back(e);
    endfunction

    // Single transaction from an idle arbiter; call and return on a negedge.
    task automatic applyStimulus(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata);
        int s;
        s            = cyc + 1;
        req[idx]     = 1'b1;
        req_we[idx]  = we;
        addr_a[idx]  = addr;
        wdata_a[idx] = wdata;
        expectGnt(idx, we, addr, wdata, s);
        if (!we) expectRead(idx, exp_rdata, s + 2);
        @(negedge clk);
        req[idx] = 1'b0;
        repeat (we ? 1 : 2) @(negedge clk);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            checkOutput("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (gnt != '0) begin
                if (gnt_q.size() == 0) begin
                    checkOutput("unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    g = gnt_q.pop_front();
                    checkOutput("gnt_value", 32'(gnt), 32'(g.gnt));
                    checkOutput("gnt_cycle", 32'(cyc), 32'(g.cyc));
                    checkOutput("gnt_mem_write", 32'(mem_write), 32'(g.we));
                    checkOutput("gnt_mem_read", 32'(mem_read), 32'(!g.we));
                    checkOutput("gnt_mem_addr", 32'(mem_addr), 32'(g.addr));
                    checkOutput("gnt_mem_data_in", 32'(mem_data_in), 32'(g.data));
                    checkOutput("gnt_busy", 32'(busy), 32'd1);
                end
            end
            if (rvalid != '0) begin
                rv_seen++;
                if (rv_q.size() == 0) begin
                    checkOutput("unexpected_rvalid", 32'(rvalid), 32'd0);
                end else begin
                    r = rv_q.pop_front();
                    checkOutput("rvalid_value", 32'(rvalid), 32'(r.rv));
                    checkOutput("rvalid_cycle", 32'(cyc), 32'(r.cyc));
                    checkOutput("rdata", 32'(rdata), 32'(r.data));
                    checkOutput("rvalid_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] wd [4];
        int s;
        int base;
        wd = '{8'h5A, 8'hC3, 8'h3C, 8'h96};

        rst_n   = 1'b0;
        req     = '0;
        req_we  = '0;
        addr_a  = '{default: '0};
        wdata_a = '{default: '0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset_rdata", 32'(rdata), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_mem_read", 32'(mem_read), 32'd0);
        checkOutput("reset_mem_write", 32'(mem_write), 32'd0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_mem_data_in", 32'(mem_data_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write issued right at reset release.
        applyStimulus(0, 1'b1, 5'h03, 8'hA5, 8'h00);
        checkOutput("write_busy_one_cycle", 32'(busy), 32'd0);
        checkOutput("write_gnt_one_cycle", 32'(gnt), 32'd0);

        // Last winner was 0; reset must bring it back so requester 0 wins first.
        applyReset();
        s = cyc + 1;
        req        = 2'b11;
        req_we     = 2'b11;
        addr_a[0]  = 5'h10;
        wdata_a[0] = 8'h11;
        addr_a[1]  = 5'h11;
        wdata_a[1] = 8'h22;
        expectGnt(0, 1'b1, 5'h10, 8'h11, s);
        expectGnt(1, 1'b1, 5'h11, 8'h22, s + 2);
        expectGnt(0, 1'b1, 5'h10, 8'h11, s + 4);
        expectGnt(1, 1'b1, 5'h11, 8'h22, s + 6);
        repeat (7) @(negedge clk);
        req = 2'b00;
        @(negedge clk);

        // Single read by requester 1 of the first write.
        applyStimulus(1, 1'b0, 5'h03, 8'h00, 8'hA5);

        // Reset during CAPTURE aborts the read.
        s = cyc + 1;
        req[0]     = 1'b1;
        req_we[0]  = 1'b0;
        addr_a[0]  = 5'h03;
        wdata_a[0] = 8'h00;
        expectGnt(0, 1'b0, 5'h03, 8'h00, s);
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        checkOutput("busy_in_capture", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_gnt", 32'(gnt), 32'd0);
        checkOutput("abort_rvalid", 32'(rvalid), 32'd0);
        checkOutput("abort_rdata", 32'(rdata), 32'd0);
        checkOutput("abort_mem_read", 32'(mem_read), 32'd0);
        checkOutput("abort_mem_write", 32'(mem_write), 32'd0);
        checkOutput("abort_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("abort_mem_data_in", 32'(mem_data_in), 32'd0);
        base = rv_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("no_rvalid_after_abort", 32'(rv_seen - base), 32'd0);

        // Back-to-back writes from requester 0: one grant every two cycles.
        s = cyc + 1;
        req[0]     = 1'b1;
        req_we[0]  = 1'b1;
        addr_a[0]  = 5'h00;
        wdata_a[0] = wd[0];
        for (int i = 0; i < 4; i++) expectGnt(0, 1'b1, 5'(i), wd[i], s + 2 * i);
        for (int i = 0; i < 4; i++) begin
            repeat ((i == 0) ? 1 : 2) @(negedge clk);
            if (i < 3) begin
                addr_a[0]  = 5'(i + 1);
                wdata_a[0] = wd[i + 1];
            end else begin
                req[0] = 1'b0;
            end
        end
        @(negedge clk);

        // Back-to-back readback from requester 1: one grant every three cycles.
        s = cyc + 1;
        req[1]     = 1'b1;
        req_we[1]  = 1'b0;
        addr_a[1]  = 5'h00;
        wdata_a[1] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            expectGnt(1, 1'b0, 5'(i), 8'h00, s + 3 * i);
            expectRead(1, wd[i], s + 3 * i + 2);
        end
        for (int i = 0; i < 4; i++) begin
            repeat ((i == 0) ? 1 : 3) @(negedge clk);
            if (i < 3) addr_a[1] = 5'(i + 1);
            else       req[1] = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Requester 1 arrives while requester 0's write is in ACCESS.
        s = cyc + 1;
        req[0]     = 1'b1;
        req_we[0]  = 1'b1;
        addr_a[0]  = 5'h08;
        wdata_a[0] = 8'h77;
        expectGnt(0, 1'b1, 5'h08, 8'h77, s);
        @(negedge clk);
        req[0]     = 1'b0;
        req[1]     = 1'b1;
        req_we[1]  = 1'b0;
        addr_a[1]  = 5'h08;
        wdata_a[1] = 8'h00;
        expectGnt(1, 1'b0, 5'h08, 8'h00, s + 2);
        expectRead(1, 8'h77, s + 4);
        repeat (2) @(negedge clk);
        req[1] = 1'b0;
        repeat (2) @(negedge clk);

        repeat (4) @(negedge clk);
        checkOutput("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
        checkOutput("rvalid_queue_drained", 32'(rv_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
